cla_serial_adder: RTL and testbench

//  Multi-cycle WIDTH-bit adder/subtractor. Processes one 4-bit nibble per clock.

---
 rtl/alu_pkg.sv | 12 +
 rtl/cla_serial_adder_if.sv | 30 +++
 rtl/cla_serial_adder_nibble.sv | 30 +++
 rtl/cla_serial_adder.sv | 134 +++++++++++++
 tb/tb_cla_serial_adder.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer state encoding and nibble geometry.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE_W = 4;

endpackage

// File: rtl/cla_serial_adder_if.sv
// Start/done handshake and operand/result bus between the ALU sequencer and the serial adder.
interface cla_serial_adder_if #(
  parameter int WIDTH = 16
);

  logic             start;
  logic             sub;
  logic             c_in;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;
  logic             zero;

  // Sequencer side: issues requests, observes results.
  modport master (
    output start, sub, c_in, a, b,
    input  busy, done, sum, c_out, ovf, zero
  );

  // Adder side: accepts requests, produces results.
  modport slave (
    input  start, sub, c_in, a, b,
    output busy, done, sum, c_out, ovf, zero
  );

endinterface

// File: rtl/cla_serial_adder_nibble.sv
// Combinational 4-bit carry-lookahead slice producing the nibble sum,
// the carry into bit 3 and the group propagate/generate.
module cla_nibble_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       c3,
  output logic       p_grp,
  output logic       g_grp
);

  logic [3:0] p;
  logic [3:0] g;
  logic       c1;
  logic       c2;

  // Two-level lookahead carries and group terms, all computed from cin directly.
  always_comb begin
    p     = a ^ b;
    g     = a & b;
    c1    = g[0] | (p[0] & cin);
    c2    = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c3    = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    p_grp = &p;
    g_grp = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    s     = p ^ {c3, c2, c1, cin};
  end

endmodule

// File: rtl/cla_serial_adder.sv
// Multi-cycle adder/subtractor: one nibble per clock through a lookahead slice,
// with a registered ripple carry linking consecutive nibbles.
module cla_serial_adder
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  cla_serial_adder_if.slave   bus
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NIBBLES - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [NIBBLE_W-1:0] nib_a;
  logic [NIBBLE_W-1:0] nib_b;
  logic [NIBBLE_W-1:0] nib_s;
  logic                nib_c3;
  logic                nib_p;
  logic                nib_g;
  logic                accept;

  assign nib_a = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
  assign nib_b = b_q[idx_q*NIBBLE_W +: NIBBLE_W];

  cla_nibble_slice u_slice (
    .a     (nib_a),
    .b     (nib_b),
    .cin   (carry_q),
    .s     (nib_s),
    .c3    (nib_c3),
    .p_grp (nib_p),
    .g_grp (nib_g)
  );

  // Next-state logic: accept requests in IDLE/DONE, step one nibble per RUN cycle,
  // and publish the full result only on the last nibble.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    work_d  = work_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    accept  = 1'b0;

    case (state_q)
      IDLE: begin
        accept = bus.start;
      end
      RUN: begin
        work_d[idx_q*NIBBLE_W +: NIBBLE_W] = nib_s;
        carry_d = nib_g | (nib_p & carry_q);
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          sum_d   = work_d;
          c_out_d = carry_d;
          ovf_d   = nib_c3 ^ carry_d;
          zero_d  = (work_d == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        accept  = bus.start;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      a_d     = bus.a;
      b_d     = bus.b ^ {WIDTH{bus.sub}};
      carry_d = bus.sub ? 1'b1 : bus.c_in;
      idx_d   = '0;
      work_d  = '0;
      state_d = RUN;
    end
  end

  // State, datapath and result registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.busy  = (state_q == RUN);
  assign bus.done  = (state_q == DONE);
  assign bus.sum   = sum_q;
  assign bus.c_out = c_out_q;
  assign bus.ovf   = ovf_q;
  assign bus.zero  = zero_q;

endmodule

// File: tb/tb_cla_serial_adder.sv
// Directed bench for the serial CLA adder: a 16-bit and a 4-bit instance.
module tb_cla_serial_adder;

  logic clk;
  logic rst_n;
  int   compares;
  int   mismatches;

  cla_serial_adder_if #(.WIDTH(16)) bus16 ();
  cla_serial_adder_if #(.WIDTH(4))  bus4 ();

  cla_serial_adder #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  cla_serial_adder #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something wedges the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compares++;
    if (actual !== expected) begin
      mismatches++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // One 16-bit operation: pulse start, scramble inputs after acceptance, check latency and results.
  task automatic applyStimulus(input string tag, input logic sub, input logic cin,
                               input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] exp_sum, input logic exp_cout,
                               input logic exp_ovf, input logic exp_zero);
    int cycles;
    @(posedge clk);
    #1;
    bus16.sub   = sub;
    bus16.c_in  = cin;
    bus16.a     = a;
    bus16.b     = b;
    bus16.start = 1'b1;
    @(posedge clk);
    #1;
    bus16.start = 1'b0;
    bus16.a     = 16'hDEAD;
    bus16.b     = 16'hBEEF;
    bus16.sub   = ~sub;
    bus16.c_in  = ~cin;
    cycles = 0;
    while (cycles <= 20) begin
      @(negedge clk);
      cycles++;
      if (bus16.done) break;
    end
    checkOutput({tag, "_latency"}, cycles, 5);
    checkOutput({tag, "_sum"},   {16'h0, bus16.sum}, {16'h0, exp_sum});
    checkOutput({tag, "_c_out"}, {31'h0, bus16.c_out}, {31'h0, exp_cout});
    checkOutput({tag, "_ovf"},   {31'h0, bus16.ovf}, {31'h0, exp_ovf});
    checkOutput({tag, "_zero"},  {31'h0, bus16.zero}, {31'h0, exp_zero});
    checkOutput({tag, "_busy_at_done"}, {31'h0, bus16.busy}, 32'h0);
    @(negedge clk);
    checkOutput({tag, "_done_one_cycle"}, {31'h0, bus16.done}, 32'h0);
  endtask

  // Directed scenarios with hand-computed results.
  initial begin
    int done_cnt;
    logic [15:0] sum_at_done;

    compares    = 0;
    mismatches  = 0;
    rst_n       = 1'b0;
    bus16.start = 1'b0;
    bus16.sub   = 1'b0;
    bus16.c_in  = 1'b0;
    bus16.a     = '0;
    bus16.b     = '0;
    bus4.start  = 1'b0;
    bus4.sub    = 1'b0;
    bus4.c_in   = 1'b0;
    bus4.a      = '0;
    bus4.b      = '0;

    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    $display("[TB] checking reset state");
    checkOutput("reset_busy",  {31'h0, bus16.busy},  32'h0);
    checkOutput("reset_done",  {31'h0, bus16.done},  32'h0);
    checkOutput("reset_sum",   {16'h0, bus16.sum},   32'h0);
    checkOutput("reset_c_out", {31'h0, bus16.c_out}, 32'h0);
    checkOutput("reset_ovf",   {31'h0, bus16.ovf},   32'h0);
    checkOutput("reset_zero",  {31'h0, bus16.zero},  32'h0);

    $display("[TB] directed 16-bit vectors");
    applyStimulus("add_basic",   1'b0, 1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 1'b0);
    applyStimulus("add_wrap",    1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1);
    applyStimulus("add_ovf",     1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0);
    applyStimulus("sub_borrow",  1'b1, 1'b0, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    applyStimulus("add_cin",     1'b0, 1'b1, 16'h00FF, 16'h0000, 16'h0100, 1'b0, 1'b0, 1'b0);
    applyStimulus("sub_ovf_cin", 1'b1, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0);

    $display("[TB] start while busy is ignored");
    @(posedge clk);
    #1;
    bus16.sub   = 1'b0;
    bus16.c_in  = 1'b0;
    bus16.a     = 16'h1111;
    bus16.b     = 16'h2222;
    bus16.start = 1'b1;
    @(posedge clk);
    #1;
    bus16.start = 1'b0;
    repeat (2) @(negedge clk);
    bus16.a     = 16'hAAAA;
    bus16.b     = 16'h5555;
    bus16.c_in  = 1'b1;
    bus16.start = 1'b1;
    @(posedge clk);
    #1;
    bus16.start = 1'b0;
    done_cnt    = 0;
    sum_at_done = 16'h0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus16.done) begin
        done_cnt++;
        sum_at_done = bus16.sum;
      end
    end
    checkOutput("busy_start_done_count", done_cnt, 1);
    checkOutput("busy_start_sum", {16'h0, sum_at_done}, 32'h3333);

    $display("[TB] reset mid-run");
    @(posedge clk);
    #1;
    bus16.a     = 16'h1234;
    bus16.b     = 16'h1111;
    bus16.c_in  = 1'b0;
    bus16.start = 1'b1;
    @(posedge clk);
    #1;
    bus16.start = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_busy", {31'h0, bus16.busy}, 32'h0);
    checkOutput("rst_mid_done", {31'h0, bus16.done}, 32'h0);
    checkOutput("rst_mid_sum",  {16'h0, bus16.sum},  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus16.done) done_cnt++;
    end
    checkOutput("rst_mid_no_done", done_cnt, 0);
    applyStimulus("after_reset", 1'b0, 1'b0, 16'h0F0F, 16'h00F1, 16'h1000, 1'b0, 1'b0, 1'b0);

    $display("[TB] 4-bit instance");
    @(posedge clk);
    #1;
    bus4.sub   = 1'b0;
    bus4.c_in  = 1'b0;
    bus4.a     = 4'h9;
    bus4.b     = 4'h8;
    bus4.start = 1'b1;
    @(posedge clk);
    #1;
    bus4.start = 1'b0;
    begin
      int cycles;
      cycles = 0;
      while (cycles <= 10) begin
        @(negedge clk);
        cycles++;
        if (bus4.done) break;
      end
      checkOutput("w4_latency", cycles, 2);
    end
    checkOutput("w4_sum",   {28'h0, bus4.sum},   32'h1);
    checkOutput("w4_c_out", {31'h0, bus4.c_out}, 32'h1);
    checkOutput("w4_ovf",   {31'h0, bus4.ovf},   32'h1);
    checkOutput("w4_zero",  {31'h0, bus4.zero},  32'h0);

    // Hold start: accepted from IDLE, then re-accepted from every DONE.
    @(posedge clk);
    @(posedge clk);
    #1;
    bus4.start = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      checkOutput($sformatf("w4_b2b_done_%0d", i), {31'h0, bus4.done}, {31'h0, (i % 2 == 0)});
      if (i % 2 == 0)
        checkOutput($sformatf("w4_b2b_sum_%0d", i), {28'h0, bus4.sum}, 32'h1);
    end
    bus4.start = 1'b0;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
    $finish;
  end

endmodule
